// File: rtl/eeg_frame_aligner.sv
// rtl/eeg_frame_aligner.sv - EEG serial frame aligner: sync hunt/track, sample capture, output FIFO
// Optional frame counter enabled by defining EEG_FRAME_CNT_EN.
module eeg_frame_aligner #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] SYNC_WORD  = 4'hA,
  parameter int               N_SAMPLES  = 8,
  parameter int               MAX_MISS   = 2,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] eegIn,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  input  logic             dready,
  output logic             locked,
  output logic             overflow,
  output logic [15:0]      frame_cnt
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int MW = $clog2(MAX_MISS + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [SW-1:0] SMP_LAST  = SW'(N_SAMPLES - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MAX_MISS - 1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [1:0] {HUNT, CAPTURE, CHECK} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] smp_q, smp_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          push;
  logic          boundary;
  logic          sync_hit;

  assign boundary = (bit_cnt_q == BIT_LAST);
  assign sync_hit = (eegIn == SYNC_WORD);
  assign locked   = (state_q != HUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      bit_cnt_q <= '0;
      smp_q     <= '0;
      miss_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      smp_q     <= smp_d;
      miss_q    <= miss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    smp_d     = smp_q;
    miss_d    = miss_q;
    push      = 1'b0;
    case (state_q)
      HUNT: begin
        if (sync_hit) begin
          state_d   = CAPTURE;
          bit_cnt_d = '0;
          smp_d     = '0;
          miss_d    = '0;
        end
      end
      CAPTURE: begin
        bit_cnt_d = boundary ? '0 : bit_cnt_q + BW'(1);
        if (boundary) begin
          push = 1'b1;
          if (smp_q == SMP_LAST) begin
            smp_d   = '0;
            state_d = CHECK;
          end else begin
            smp_d = smp_q + SW'(1);
          end
        end
      end
      CHECK: begin
        bit_cnt_d = boundary ? '0 : bit_cnt_q + BW'(1);
        if (boundary) begin
          // A miss that reaches the limit drops lock without counting the frame.
          if (sync_hit) begin
            miss_d  = '0;
            state_d = CAPTURE;
          end else if (miss_q == MISS_LAST) begin
            miss_d  = '0;
            state_d = HUNT;
          end else begin
            miss_d  = miss_q + MW'(1);
            state_d = CAPTURE;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_next, rd_next;
  logic             empty, full, pop, wr_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dvalid  = !empty;
  assign pop     = dvalid && dready;
  assign wr_en   = push && (!full || pop);
  assign wr_next = wr_en ? wr_ptr + PTR_ONE : wr_ptr;
  assign rd_next = pop ? rd_ptr + PTR_ONE : rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= eegIn;
  end

  // dout tracks the next head; when that slot is being written this edge, bypass eegIn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      if (rd_next != wr_next)
        dout <= (wr_en && (rd_next == wr_ptr)) ? eegIn : mem[rd_next[AW-1:0]];
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

`ifdef EEG_FRAME_CNT_EN
  logic        frame_done;
  logic [15:0] frame_cnt_q;

  assign frame_done = (state_q == CHECK) && boundary && (sync_hit || (miss_q != MISS_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_eeg_frame_aligner.sv
// tb/tb_eeg_frame_aligner.sv - randomized self-checking bench for eeg_frame_aligner
module tb_eeg_frame_aligner;
  localparam int         W     = 4;
  localparam logic [3:0] SYNC  = 4'hA;
  localparam int         NS    = 8;
  localparam int         MM    = 2;
  localparam int         DEPTH = 4;
  localparam int         MAXC  = 512;
`ifdef EEG_FRAME_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  eegIn = 4'h0;
  logic        dready = 1'b0;
  logic [3:0]  dout;
  logic        dvalid, locked, overflow;
  logic [15:0] frame_cnt;

  eeg_frame_aligner #(
    .WIDTH(W), .SYNC_WORD(SYNC), .N_SAMPLES(NS), .MAX_MISS(MM), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .eegIn(eegIn), .dout(dout), .dvalid(dvalid),
    .dready(dready), .locked(locked), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  bit sbit [MAXC];
  bit rdy  [MAXC];
  int slen;
  int obs_q [$];

  task automatic add_word(input int w, input bit r);
    for (int i = W - 1; i >= 0; i--) begin
      sbit[slen] = w[i];
      rdy[slen]  = r;
      slen++;
    end
  endtask

  task automatic add_bits(input int n, input bit v, input bit r);
    for (int i = 0; i < n; i++) begin
      sbit[slen] = v;
      rdy[slen]  = r;
      slen++;
    end
  endtask

  // Reference: walk the bit stream by absolute word positions, then replay through a queue FIFO.
  task automatic run_stream();
    int win [MAXC];
    bit pv [MAXC];
    int pd [MAXC];
    bit la [MAXC];
    int fa [MAXC];
    int q [$];
    int w, k, nb, miss, fc, last, ef;
    bit lk, ov, el;
    w = 0; lk = 0; fc = 0; k = 0; nb = 0; miss = 0;
    for (int c = 0; c < slen; c++) begin
      w = ((w << 1) | int'(sbit[c])) & ((1 << W) - 1);
      win[c] = w; pv[c] = 0; pd[c] = 0;
      if (!lk) begin
        if (w == SYNC) begin lk = 1; nb = c + W; k = 0; miss = 0; end
      end else if (c == nb) begin
        nb = c + W;
        if (k < NS) begin
          pv[c] = 1; pd[c] = w; k++;
        end else begin
          k = 0;
          if (w == SYNC) begin miss = 0; fc++; end
          else if (miss + 1 == MM) lk = 0;
          else begin miss++; fc++; end
        end
      end
      la[c] = lk;
      fa[c] = CNT_EN ? (fc % 65536) : 0;
    end
    obs_q.delete();
    last = 0; ov = 0; el = 0; ef = 0;
    rst_n = 1'b0; eegIn = 4'h0; dready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c <= slen; c++) begin
      ncmp++;
      if (dvalid !== (q.size() > 0)) begin
        nfail++; $display("FAIL dvalid c=%0d got %0b want %0b", c, dvalid, q.size() > 0);
      end
      ncmp++;
      if (dout !== 4'(last)) begin
        nfail++; $display("FAIL dout c=%0d got %0h want %0h", c, dout, last);
      end
      ncmp++;
      if (locked !== el) begin
        nfail++; $display("FAIL locked c=%0d got %0b want %0b", c, locked, el);
      end
      ncmp++;
      if (overflow !== ov) begin
        nfail++; $display("FAIL overflow c=%0d got %0b want %0b", c, overflow, ov);
      end
      ncmp++;
      if (frame_cnt !== 16'(ef)) begin
        nfail++; $display("FAIL frame_cnt c=%0d got %0d want %0d", c, frame_cnt, ef);
      end
      if (c < slen) begin
        eegIn  = 4'(win[c]);
        dready = rdy[c];
        if (dvalid && dready) obs_q.push_back(int'(dout));
        if (q.size() > 0 && rdy[c]) void'(q.pop_front());
        if (pv[c]) begin
          if (q.size() < DEPTH) q.push_back(pd[c]);
          else ov = 1;
        end
        if (q.size() > 0) last = q[0];
        el = la[c];
        ef = fa[c];
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; eegIn = 4'h0; dready = 1'b1;
    repeat (2) @(negedge clk);
    ncmp++; if (dvalid !== 1'b0) begin nfail++; $display("FAIL reset_dvalid got %0b want 0", dvalid); end
    ncmp++; if (locked !== 1'b0) begin nfail++; $display("FAIL reset_locked got %0b want 0", locked); end
    ncmp++; if (overflow !== 1'b0) begin nfail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    ncmp++; if (dout !== 4'h0) begin nfail++; $display("FAIL reset_dout got %0h want 0", dout); end
    ncmp++; if (frame_cnt !== 16'd0) begin nfail++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    ncmp++; if (locked !== 1'b0) begin nfail++; $display("FAIL idle_locked got %0b want 0", locked); end
  endtask

  task automatic test_basic_stream();
    slen = 0;
    add_word(SYNC, 1);
    for (int i = 1; i <= 8; i++) add_word(i, 1);
    add_word(SYNC, 1);
    add_word(9, 1);
    add_bits(3, 0, 1);
    run_stream();
    ncmp++;
    if (obs_q.size() != 9) begin
      nfail++; $display("FAIL basic_count got %0d want 9", obs_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        ncmp++;
        if (obs_q[i] != i + 1) begin nfail++; $display("FAIL basic_seq[%0d] got %0d want %0d", i, obs_q[i], i + 1); end
      end
    end
    ncmp++; if (frame_cnt !== 16'(CNT_EN ? 1 : 0)) begin nfail++; $display("FAIL basic_frames got %0d want %0d", frame_cnt, CNT_EN ? 1 : 0); end
  endtask

  task automatic test_miss_relock();
    int wds [16];
    slen = 0;
    add_word(SYNC, 1);
    for (int i = 0; i < 8; i++) begin wds[i] = $urandom_range(0, 15); add_word(wds[i], 1); end
    add_word(5, 1);
    for (int i = 8; i < 16; i++) begin wds[i] = $urandom_range(0, 15); add_word(wds[i], 1); end
    add_word(3, 1);
    add_bits(8, 0, 1);
    run_stream();
    ncmp++;
    if (obs_q.size() != 16) begin
      nfail++; $display("FAIL miss_count got %0d want 16", obs_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        ncmp++;
        if (obs_q[i] != wds[i]) begin nfail++; $display("FAIL miss_seq[%0d] got %0d want %0d", i, obs_q[i], wds[i]); end
      end
    end
    ncmp++; if (locked !== 1'b0) begin nfail++; $display("FAIL miss_locked got %0b want 0", locked); end
    ncmp++; if (frame_cnt !== 16'(CNT_EN ? 1 : 0)) begin nfail++; $display("FAIL miss_frames got %0d want %0d", frame_cnt, CNT_EN ? 1 : 0); end
  endtask

  task automatic test_overflow();
    slen = 0;
    add_word(SYNC, 0);
    for (int i = 1; i <= 6; i++) add_word(i, 0);
    add_bits(2, 0, 0);
    add_bits(8, 0, 1);
    run_stream();
    ncmp++;
    if (obs_q.size() < 4) begin
      nfail++; $display("FAIL ovf_count got %0d want >=4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        ncmp++;
        if (obs_q[i] != i + 1) begin nfail++; $display("FAIL ovf_seq[%0d] got %0d want %0d", i, obs_q[i], i + 1); end
      end
    end
    ncmp++; if (overflow !== 1'b1) begin nfail++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    slen = 0;
    add_word(SYNC, 0);
    for (int i = 1; i <= 5; i++) add_word(i, 0);
    rdy[slen - 1] = 1;
    add_bits(3, 0, 1);
    run_stream();
    ncmp++;
    if (obs_q.size() != 4) begin
      nfail++; $display("FAIL full_count got %0d want 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        ncmp++;
        if (obs_q[i] != i + 1) begin nfail++; $display("FAIL full_seq[%0d] got %0d want %0d", i, obs_q[i], i + 1); end
      end
    end
    ncmp++; if (overflow !== 1'b0) begin nfail++; $display("FAIL full_overflow got %0b want 0", overflow); end
    ncmp++; if (dvalid !== 1'b1) begin nfail++; $display("FAIL full_dvalid got %0b want 1", dvalid); end
    ncmp++; if (dout !== 4'h5) begin nfail++; $display("FAIL full_dout got %0h want 5", dout); end
  endtask

  task automatic test_random();
    int tw;
    for (int run = 0; run < 3; run++) begin
      slen = 0;
      for (int i = $urandom_range(0, 9); i > 0; i--) add_bits(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, run + 1) != 0));
      add_word(SYNC, 1);
      for (int f = 0; f < 3; f++) begin
        for (int i = 0; i < 8; i++) add_word($urandom_range(0, 15), 1'($urandom_range(0, run + 1) != 0));
        tw = $urandom_range(0, 15);
        if ($urandom_range(0, 3) != 0) tw = SYNC;
        else if (tw == SYNC) tw = 5;
        add_word(tw, 1'($urandom_range(0, 1)));
      end
      add_bits(6, 1'($urandom_range(0, 1)), 1);
      run_stream();
    end
  endtask

  task automatic test_async_reset();
    slen = 0;
    add_word(SYNC, 0);
    for (int i = 1; i <= 6; i++) add_word(i, 0);
    add_bits(2, 0, 0);
    run_stream();
    #2;
    ncmp++; if (locked !== 1'b1) begin nfail++; $display("FAIL pre_rst_locked got %0b want 1", locked); end
    ncmp++; if (overflow !== 1'b1) begin nfail++; $display("FAIL pre_rst_overflow got %0b want 1", overflow); end
    rst_n = 1'b0;
    #1;
    ncmp++; if (dvalid !== 1'b0) begin nfail++; $display("FAIL arst_dvalid got %0b want 0", dvalid); end
    ncmp++; if (locked !== 1'b0) begin nfail++; $display("FAIL arst_locked got %0b want 0", locked); end
    ncmp++; if (overflow !== 1'b0) begin nfail++; $display("FAIL arst_overflow got %0b want 0", overflow); end
    ncmp++; if (dout !== 4'h0) begin nfail++; $display("FAIL arst_dout got %0h want 0", dout); end
    slen = 0;
    add_bits(20, 0, 1);
    add_word(SYNC, 1);
    add_word(7, 1);
    add_word(7, 1);
    add_bits(3, 0, 1);
    run_stream();
    ncmp++;
    if (obs_q.size() != 2 || obs_q[0] != 7 || obs_q[1] != 7) begin
      nfail++; $display("FAIL post_rst_seq got %0d items want 2 of 7", obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_miss_relock();
    test_overflow();
    test_full_pop();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/eeg_frame_aligner.md
EEG_FRAME_ALIGNER -- requirements
Module: eeg_frame_aligner

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH  4  sample word width in bits
  SYNC_WORD  4'hA  frame sync pattern, WIDTH bits
  N_SAMPLES  8  data words per frame
  MAX_MISS  2  consecutive sync misses before relock
  FIFO_DEPTH  4  output FIFO entries, power of two
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  eegIn  in  WIDTH  upstream deserializer shift window; advances one bit per clk
  dout  out  WIDTH  FIFO head sample
  dvalid  out  1  dout holds a valid sample
  dready  in  1  consumer accepts dout when dvalid&&dready
  locked  out  1  high in CAPTURE or CHECK
  overflow  out  1  sticky: a sample was dropped
  frame_cnt  out  16  completed frames (see REQ-017)

Function
REQ-003 States SHALL be HUNT, CAPTURE, CHECK; bit counter bit_cnt 0..WIDTH-1; sample counter smp 0..N_SAMPLES-1; miss counter 0..MAX_MISS.
REQ-004 HUNT: on any cycle with eegIn==SYNC_WORD, go to CAPTURE, set bit_cnt=0, smp=0, miss=0; otherwise remain.
REQ-005 In CAPTURE/CHECK bit_cnt SHALL increment each clk, wrapping WIDTH-1->0; a word boundary is a cycle with bit_cnt==WIDTH-1, i.e. exactly WIDTH cycles after the sync match or the previous boundary.
REQ-006 CAPTURE boundary: eegIn SHALL be pushed to the FIFO; smp increments; on smp==N_SAMPLES-1 go to CHECK, smp=0.
REQ-007 CHECK boundary: eegIn==SYNC_WORD -> CAPTURE, miss=0, frame completed; mismatch -> miss+1, frame completed, CAPTURE; if miss+1==MAX_MISS -> HUNT instead, no frame completed.
REQ-008 Words examined in CHECK SHALL never be pushed; eegIn SHALL be ignored outside boundaries in CAPTURE/CHECK.
REQ-009 Push-to-dvalid latency SHALL be one clk when the FIFO was empty (dout registered from storage).
REQ-010 Pop SHALL occur on dvalid&&dready; dout/dvalid SHALL change only on the following edge.
REQ-011 FIFO full with push and no pop: sample dropped, overflow set to 1 and held until reset; FIFO contents unchanged.
REQ-012 FIFO full with push and pop in the same cycle: both SHALL succeed, no overflow.
REQ-013 FIFO empty: dvalid=0; dout holds last value; dready ignored.
REQ-014 Loss of lock (CHECK->HUNT) SHALL NOT flush the FIFO; queued samples remain poppable.
REQ-015 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy tracked with one extra pointer bit to distinguish full from empty.

Reset
REQ-016 rst_n low SHALL asynchronously force: state HUNT, bit_cnt/smp/miss 0, FIFO empty, dout 0, dvalid 0, locked 0, overflow 0, frame_cnt 0; release is sampled at the next rising clk; reset mid-frame discards partial frame and queued samples.

Configuration
REQ-017 Macro EEG_FRAME_CNT_EN defined: frame_cnt increments by 1 per completed frame (REQ-007), wrapping 16'hFFFF->0; undefined: counter logic absent, frame_cnt tied to 0.

Verification (WIDTH=4, SYNC=4'hA, N_SAMPLES=8, MAX_MISS=2, FIFO_DEPTH=4)
REQ-018 Serial stream A,1,2,...,8,A,9 via upstream shift register, dready=1 -> locked rises one clk after first A window; dout sequence 1..8 then 9, each dvalid one clk after its boundary; frame_cnt=1 after second A.
REQ-019 Frame of 8 samples, trailer 4'h5, trailer 4'h3 -> first miss keeps locked=1 and captures next frame; second miss -> HUNT, locked=0; frame_cnt incremented once only.
REQ-020 dready=0, 6 samples delivered -> first 4 retained, overflow=1 on 5th push; then dready=1 -> pops return samples 1,2,3,4 in order.
REQ-021 FIFO full, dready=1 on a boundary cycle -> sample accepted, overflow stays 0, occupancy stays 4.
REQ-022 rst_n pulled low mid-frame asynchronously (no clk edge) -> dvalid, locked, overflow immediately 0; after release, no output until new A window.
REQ-023 Build without EEG_FRAME_CNT_EN, run REQ-018 stimulus -> identical dout/dvalid, frame_cnt constant 0.
